// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM states, the latched bus mode and width helpers
// used to size chip-select indices and the small internal counters.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int cs_sel_width(input int num_cs);
        return (num_cs > 32'sd1) ? $clog2(num_cs) : 32'sd1;
    endfunction

    // Bits needed to hold 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 32'sd1) ? $clog2(max_count) : 32'sd1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk by CLK_DIV while enabled and flags each
// leading (away from idle) and trailing (back to idle) SCLK transition.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic load_cpol,
    input  logic cpol,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'sd1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             sclk_r;
    logic             tick_s;

    // Half-period tick and its classification against the idle level.
    always_comb begin
        tick_s    = en && (div_cnt_r == DIV_LAST);
        lead_stb  = tick_s && (sclk_r == cpol);
        trail_stb = tick_s && (sclk_r != cpol);
    end

    // Divider counter, parked at zero whenever the shift phase is inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else if (!en || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
        end
    end

    // SCLK level: preset to the requested idle level on load, toggled on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_r <= 1'b0;
        end else if (load) begin
            sclk_r <= load_cpol;
        end else if (tick_s) begin
            sclk_r <= ~sclk_r;
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: start/busy/send_complete handshake,
// four CPOL/CPHA modes, one-hot active-low chip selects, MSB/LSB-first order.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  CLK_DIV   = 2,
    parameter int  NUM_CS    = 1,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CS_SEL_W  = cs_sel_width(NUM_CS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   send_data,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic                cpol,
    input  logic                cpha,
    output logic                busy,
    output logic                send_complete,
    output logic [DATA_W-1:0]   recv_data,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic [NUM_CS-1:0]   CS
);

    localparam int PH_W  = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(DATA_W);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 32'sd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 32'sd1);

    spi_state_t        state_r, state_s;
    spi_mode_t         mode_r;
    logic [PH_W-1:0]   phase_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_r, rx_r, recv_r;
    logic [NUM_CS-1:0] cs_r;
    logic              busy_r, done_r, mosi_r;
    logic              load_s, finish_s, xfer_s, phase_end_s, last_bit_s;
    logic              lead_stb_s, trail_stb_s, adv_s, samp_s;

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b);
        return MSB_FIRST ? {d[DATA_W-2:0], b} : {b, d[DATA_W-1:1]};
    endfunction

    // Out-of-range selects leave every line deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_SEL_W'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = v[i];
            end
        end
        return v;
    endfunction

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (xfer_s),
        .load      (load_s),
        .load_cpol (cpol),
        .cpol      (mode_r.cpol),
        .lead_stb  (lead_stb_s),
        .trail_stb (trail_stb_s),
        .sclk      (SCLK)
    );

    // Next-state logic plus the per-cycle control strobes.
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        finish_s    = 1'b0;
        xfer_s      = (state_r == XFER);
        phase_end_s = (phase_r == PH_LAST);
        last_bit_s  = (bit_cnt_r == BIT_LAST);
        adv_s       = mode_r.cpha ? lead_stb_s : (trail_stb_s && !last_bit_s);
        samp_s      = mode_r.cpha ? trail_stb_s : lead_stb_s;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SETUP;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (phase_end_s) state_s = XFER;
                else             state_s = SETUP;
            end
            XFER: begin
                if (trail_stb_s && last_bit_s) state_s = HOLD;
                else                           state_s = XFER;
            end
            HOLD: begin
                if (phase_end_s) begin
                    state_s  = IDLE;
                    finish_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // SETUP/HOLD dwell counter and trailing-edge bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r   <= '0;
            bit_cnt_r <= '0;
        end else begin
            if ((state_r == SETUP || state_r == HOLD) && !phase_end_s) begin
                phase_r <= phase_r + PH_W'(1'b1);
            end else begin
                phase_r <= '0;
            end
            if (load_s) begin
                bit_cnt_r <= '0;
            end else if (trail_stb_s && !last_bit_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
            end
        end
    end

    // Transfer datapath: capture on start, shift on strobes, publish on finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            recv_r <= '0;
            mosi_r <= 1'b0;
            cs_r   <= '1;
            mode_r <= '0;
            tx_r   <= '0;
            rx_r   <= '0;
        end else begin
            done_r <= finish_s;
            if (load_s) begin
                busy_r      <= 1'b1;
                mode_r.cpol <= cpol;
                mode_r.cpha <= cpha;
                cs_r        <= cs_decode(cs_sel);
                rx_r        <= '0;
                // cpha=0 presents the first bit before the first SCLK edge.
                if (cpha) begin
                    tx_r   <= send_data;
                    mosi_r <= 1'b0;
                end else begin
                    tx_r   <= shift_out(send_data);
                    mosi_r <= first_bit(send_data);
                end
            end else if (finish_s) begin
                busy_r <= 1'b0;
                cs_r   <= '1;
                mosi_r <= 1'b0;
                recv_r <= rx_r;
            end else begin
                if (adv_s) begin
                    mosi_r <= first_bit(tx_r);
                    tx_r   <= shift_out(tx_r);
                end
                if (samp_s) begin
                    rx_r <= shift_in(rx_r, MISO);
                end
            end
        end
    end

    assign busy          = busy_r;
    assign send_complete = done_r;
    assign recv_data     = recv_r;
    assign MOSI          = mosi_r;
    assign CS            = cs_r;

endmodule
